// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter and select sequencer for the 8:1 mux tree (optional hold timeout: MUX8_ARB_TIMEOUT_EN)
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       valid,
  output logic [2:0] sel,
  output logic       tmo
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] pick;
  logic       pick_ok;
  logic       hold_lim;
  logic       force_rel;
  logic [7:0] gnt_d;
  logic       valid_d;
  logic [2:0] sel_d;
  logic       tmo_d;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q;

  // hold counter: zero on grant, counts every BUSY cycle after that
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (state_q == IDLE && pick_ok) begin
      cnt_q <= 8'd0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign hold_lim = (cnt_q == LIMIT);
`else
  // without the timeout there is no hold bound; MAX_HOLD is legal only from 1, so this is constant 0
  assign hold_lim = (MAX_HOLD == 0);
`endif

  // first requester at or above ptr, wrapping modulo 8
  always_comb begin
    pick    = 3'd0;
    pick_ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!pick_ok && req[ptr_q + 3'(i)]) begin
        pick    = ptr_q + 3'(i);
        pick_ok = 1'b1;
      end
    end
  end

  // state, pointer and owner registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // next state: grant from IDLE, release from BUSY on drop or hold limit
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    force_rel = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = BUSY;
          owner_d = pick;
        end
      end
      BUSY: begin
        if (!req[owner_q] || hold_lim) begin
          state_d   = IDLE;
          ptr_d     = owner_q + 3'd1;
          force_rel = req[owner_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs; sel keeps the last owner while idle
  always_comb begin
    gnt_d   = 8'h00;
    valid_d = 1'b0;
    sel_d   = sel;
    tmo_d   = force_rel;
    if (state_d == BUSY) begin
      gnt_d   = 8'h01 << owner_d;
      valid_d = 1'b1;
      sel_d   = owner_d;
    end
  end

  // output registers, so nothing combinational reaches the ports from req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt   <= 8'h00;
      valid <= 1'b0;
      sel   <= 3'd0;
      tmo   <= 1'b0;
    end else begin
      gnt   <= gnt_d;
      valid <= valid_d;
      sel   <= sel_d;
      tmo   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic       valid;
  logic [2:0] sel;
  logic       tmo;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: owner -1 means no grant
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_sel   = 0;
  int m_tmo   = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic       valid;
    logic [2:0] sel;
  } vec_t;

  vec_t tbl [16];

  mux8_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .valid (valid),
    .sel   (sel),
    .tmo   (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
    m_tmo   = 0;
  endtask

  // one clock edge of the arbiter rules, applied to requests r
  task automatic model_edge(input logic [7:0] r);
    m_tmo = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (r[idx]) begin
          m_owner = idx;
          m_sel   = idx;
          m_held  = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
      if (m_held == int'(HOLD)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_tmo   = 1;
      end else begin
        m_held++;
      end
`endif
    end
  endtask

  initial begin
    logic [7:0] exp_g;

    tbl[0]  = '{8'h00, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{8'h10, 8'h10, 1'b1, 3'd4};
    tbl[2]  = '{8'h10, 8'h10, 1'b1, 3'd4};
    tbl[3]  = '{8'h00, 8'h00, 1'b0, 3'd4};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 3'd4};
    tbl[5]  = '{8'h40, 8'h40, 1'b1, 3'd6};
    tbl[6]  = '{8'h41, 8'h40, 1'b1, 3'd6};
    tbl[7]  = '{8'h01, 8'h00, 1'b0, 3'd6};
    tbl[8]  = '{8'h41, 8'h01, 1'b1, 3'd0};
    tbl[9]  = '{8'h41, 8'h01, 1'b1, 3'd0};
    tbl[10] = '{8'h40, 8'h00, 1'b0, 3'd0};
    tbl[11] = '{8'h40, 8'h40, 1'b1, 3'd6};
    tbl[12] = '{8'h00, 8'h00, 1'b0, 3'd6};
    tbl[13] = '{8'h80, 8'h80, 1'b1, 3'd7};
    tbl[14] = '{8'h00, 8'h00, 1'b0, 3'd7};
    tbl[15] = '{8'hFF, 8'h01, 1'b1, 3'd0};

    // reset state and ten idle cycles
    do_reset();
    for (int c = 0; c < 10; c++) begin
      chk("idle_gnt", gnt, 8'h00);
      chk("idle_valid", {7'd0, valid}, 8'h00);
      chk("idle_sel", {5'd0, sel}, 8'h00);
      chk("idle_tmo", {7'd0, tmo}, 8'h00);
      step();
    end

    // table: single request, non-owner changes, pointer wrap, fairness
    for (int v = 0; v < 16; v++) begin
      req = tbl[v].req;
      step();
      chk($sformatf("tbl%0d_gnt", v), gnt, tbl[v].gnt);
      chk($sformatf("tbl%0d_valid", v), {7'd0, valid}, {7'd0, tbl[v].valid});
      chk($sformatf("tbl%0d_sel", v), {5'd0, sel}, {5'd0, tbl[v].sel});
      chk($sformatf("tbl%0d_tmo", v), {7'd0, tmo}, 8'h00);
    end

    // full contention: order 0..7,0 with one idle cycle between grants
    do_reset();
    req = 8'hFF;
    step();
    chk("rr_first", gnt, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      exp_g = 8'h01 << ((k - 1) % 8);
      step();
      chk("rr_hold", gnt, exp_g);
      req = 8'hFF & ~exp_g;
      step();
      chk("rr_bubble", {7'd0, valid}, 8'h00);
      req = 8'hFF;
      step();
      chk($sformatf("rr_grant%0d", k), gnt, 8'h01 << (k % 8));
    end

    // hold timeout (or unbounded hold without it)
    do_reset();
    req = 8'h28;
    step();
    chk("to_grant", gnt, 8'h08);
`ifdef MUX8_ARB_TIMEOUT_EN
    for (int c = 1; c < int'(HOLD); c++) begin
      step();
      chk("to_hold", gnt, 8'h08);
      chk("to_hold_tmo", {7'd0, tmo}, 8'h00);
    end
    step();
    chk("to_release", gnt, 8'h00);
    chk("to_pulse", {7'd0, tmo}, 8'h01);
    step();
    chk("to_next", gnt, 8'h20);
    chk("to_next_sel", {5'd0, sel}, 8'h05);
    chk("to_pulse_end", {7'd0, tmo}, 8'h00);
`else
    for (int c = 0; c < 100; c++) begin
      step();
      chk("hold_forever", gnt, 8'h08);
      chk("hold_tmo", {7'd0, tmo}, 8'h00);
    end
`endif

    // asynchronous reset mid-BUSY
    do_reset();
    req = 8'h04;
    step();
    chk("ar_grant", gnt, 8'h04);
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt", gnt, 8'h00);
    chk("ar_valid", {7'd0, valid}, 8'h00);
    chk("ar_sel", {5'd0, sel}, 8'h00);
    #1 rst = 1'b0;
    step();
    chk("ar_regrant", gnt, 8'h04);
    chk("ar_regrant_sel", {5'd0, sel}, 8'h02);

    // randomized requests against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c < 300) req = 8'($urandom_range(0, 255));
      else         req = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255));
      model_edge(req);
      step();
      chk("rnd_gnt", gnt, (m_owner < 0) ? 8'h00 : (8'h01 << m_owner));
      chk("rnd_valid", {7'd0, valid}, (m_owner < 0) ? 8'h00 : 8'h01);
      chk("rnd_sel", {5'd0, sel}, 8'(m_sel));
      chk("rnd_tmo", {7'd0, tmo}, 8'(m_tmo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and select sequencer for the 8:1 scalar mux tree. Eight requesters compete for the shared mux output. The block grants one requester at a time and drives the mux's three select lines so that the granted requester's data input reaches `out`. An optional hold timeout stops a requester from keeping the mux indefinitely.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive granted cycles per grant when timeout is compiled in; legal range 1..255.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  8  request per requester; bit i requests data input `d<i>` of the mux.
- `gnt`  output 8  one-hot grant, registered; all zero when no grant is active.
- `valid`  output 1  high while a grant is active; equals the OR of `gnt`.
- `sel`  output 3  mux select, registered: `sel[2]` to `a`, `sel[1]` to `b`, `sel[0]` to `c`. Equals the owner index while valid.
- `tmo`  output 1  one-cycle pulse when a grant is force-released by timeout.

## Operation
- **State machine:** two states, IDLE and BUSY.
  - Round-robin pointer `ptr` (3 bits) holds the first index searched.
  - `owner` (3 bits) holds the current grantee.
- **IDLE:**
  - If `req` is nonzero, the first set bit is chosen, searching upward from `ptr` modulo 8.
  - The chosen index becomes `owner` and the state moves to BUSY.
  - `gnt` and `valid` assert and `sel` loads `owner`.
  - If `req` is zero, the state stays IDLE.
- **BUSY, normal release:** if `req[owner]` is sampled low, the state returns to IDLE.
  - `gnt` and `valid` clear.
  - `ptr` loads `owner+1` (mod 8; 7 wraps to 0).
- **BUSY, hold:** otherwise the grant holds and `gnt`, `sel` and `owner` do not change.
- **Requests from non-owners:** changes to non-owner `req` bits during BUSY have no effect.
- **`sel` when idle:** `sel` keeps the last owner index in IDLE, so the mux output stays stable; only `valid` marks it meaningful.
- **Bubble between grants:** every release is followed by at least one IDLE cycle with `valid`=0.
- **Fairness:** after a release, the released index has lowest priority at the next arbitration.
  - It is still granted again if it is the only requester.
- **Reset (asynchronous, immediate, including mid-BUSY):**
  - State IDLE.
  - `gnt`=8'h00, `valid`=0, `sel`=3'd0, `tmo`=0.
  - `ptr`=0, `owner`=0, hold counter 0.

## Timing
- **Grant latency:** `req` sampled at edge N gives `gnt`/`sel` valid after edge N+1, i.e. 1 cycle.
- **Release latency:** `req[owner]` low at edge N gives `gnt`=0 after edge N+1.
  - The earliest next grant is after edge N+2.
- **Outputs:** all outputs come straight from registers; there is no combinational path from `req` to any output.
- **Hold counter (timeout build only):**
  - Cleared on grant.
  - Increments on each BUSY cycle.
  - When `valid` has been high for `MAX_HOLD` cycles and `req[owner]` is still high, the next edge forces release.
  - On that forced release, `gnt` clears, `tmo` pulses for one cycle (coincident with the first IDLE cycle) and `ptr` loads `owner+1`.
- **Simultaneous events:** if `req[owner]` drops on the same cycle the limit is reached, the release is normal and `tmo` stays 0.

## Configuration
- Macro `MUX8_ARB_TIMEOUT_EN`.
- **Defined:** the 8-bit hold counter and forced release are built in, and `tmo` behaves as specified.
- **Undefined:**
  - There is no counter, `MAX_HOLD` is ignored and `tmo` is tied to 0.
  - A grant holds until `req[owner]` drops, with no upper bound.

## Test plan
- Reset, then `req`=8'h00 for 10 cycles: `gnt`=8'h00, `valid`=0, `sel`=0 and `tmo`=0 throughout.
- Single request: `req`=8'h10 gives `gnt`=8'h10, `sel`=3'd4 and `valid`=1 one cycle later. Dropping `req` gives `gnt`=8'h00 one cycle later, and `sel` stays 4.
- Full contention:
  - Stimulus: `req`=8'hFF from reset; each grantee drops its bit 2 cycles after its grant and re-raises it 1 cycle later.
  - Required: grant order 0,1,2,…,7,0, with exactly one idle cycle between grants.
- Pointer wrap:
  - Stimulus: last owner 6 (so `ptr`=7), then `req`=8'h41.
  - Required: next grant is `gnt`=8'h01, `sel`=0.
- Timeout, built with `MUX8_ARB_TIMEOUT_EN` and `MAX_HOLD`=4; `req`=8'h28 held constant:
  - `gnt`=8'h08 for exactly 4 cycles.
  - Then one idle cycle with `tmo`=1.
  - Then `gnt`=8'h20, `sel`=5.
  - Without the macro, `gnt`=8'h08 persists for 100 or more cycles.
- Asynchronous reset mid-BUSY: with `gnt`=8'h04, pulse `rst` between clock edges. Required: `gnt`=0, `valid`=0 and `sel`=0 immediately. With `req`=8'h04 still high after reset, the first grant comes 1 cycle after the first edge.
